// File: rtl/mb_pwm_pkg.sv
// mb_pwm_pkg: shared types, PCM constants and duty-to-PCM conversion for the PWM domain
package mb_pwm_pkg;

    typedef enum logic [0:0] {
        SEEK    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [15:0] PCM_MIDSCALE = 16'h0000;
    localparam logic [15:0] PCM_MAX      = 16'h7FFF;

    // Offset-binary duty back to two's complement; a full-frame high count saturates
    function automatic logic [15:0] duty_to_pcm(input logic [16:0] hi, input int pwm_bits);
        logic [15:0] frac;
        frac = hi[15:0] << (16 - pwm_bits);
        return (int'(hi) >= (1 << pwm_bits)) ? PCM_MAX : frac ^ 16'h8000;
    endfunction

endpackage

// File: rtl/mb_pwm_in_sync.sv
// mb_pwm_in_sync: multi-flop synchronizer for the PWM pin plus rising-edge detector
module mb_pwm_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic pwm_clk,
    input  logic rst,
    input  logic pwm_in,
    output logic lvl,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge pwm_clk) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pwm_in};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign lvl  = sync[SYNC_STAGES-1];
    assign rise = lvl & ~prev;

endmodule

// File: rtl/mb_pwm_to_pcm.sv
// mb_pwm_to_pcm: decodes a PWM carrier into one signed 16-bit PCM sample per frame, with lock status
module mb_pwm_to_pcm
    import mb_pwm_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int LOCK_FRAMES = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        pwm_clk,
    input  logic        rst,
    input  logic        pwm_in,
    output logic [15:0] pcm_out,
    output logic        pcm_valid,
    output logic        locked
);

    localparam logic [PWM_BITS-1:0] POS_LAST = '1;
    localparam logic [PWM_BITS-1:0] POS_ONE  = PWM_BITS'(1);
    localparam logic [7:0]          LOCK_TGT = 8'(LOCK_FRAMES);

    state_t              state;
    logic [PWM_BITS-1:0] pos;
    logic [PWM_BITS-1:0] tcnt;
    logic [PWM_BITS:0]   hi;
    logic [PWM_BITS:0]   hi_lvl;
    logic [PWM_BITS:0]   hi_sum;
    logic [7:0]          lock_cnt;
    logic [7:0]          lock_nxt;
    logic                lvl;
    logic                rise;

    mb_pwm_in_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .pwm_clk(pwm_clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .lvl    (lvl),
        .rise   (rise)
    );

    assign hi_lvl   = {{PWM_BITS{1'b0}}, lvl};
    assign hi_sum   = hi + hi_lvl;
    assign lock_nxt = (lock_cnt == LOCK_TGT) ? lock_cnt : lock_cnt + 8'd1;

    // A rising edge always marks position 0, so the frame it opens is pos 0 this cycle
    always_ff @(posedge pwm_clk) begin
        if (rst) begin
            state     <= SEEK;
            tcnt      <= '0;
            pos       <= '0;
            hi        <= '0;
            lock_cnt  <= '0;
            locked    <= 1'b0;
            pcm_out   <= PCM_MIDSCALE;
            pcm_valid <= 1'b0;
        end else begin
            pcm_valid <= 1'b0;
            if (state == SEEK) begin
                tcnt <= tcnt + POS_ONE;
                if (rise) begin
                    state <= MEASURE;
                    pos   <= POS_ONE;
                    hi    <= hi_lvl;
                    tcnt  <= '0;
                end else if (tcnt == POS_LAST) begin
                    state <= MEASURE;
                    pos   <= '0;
                    hi    <= '0;
                    tcnt  <= '0;
                end
            end else if (rise && pos != '0) begin
                pos      <= POS_ONE;
                hi       <= hi_lvl;
                lock_cnt <= '0;
                locked   <= 1'b0;
            end else if (pos == POS_LAST) begin
                pos       <= '0;
                hi        <= '0;
                pcm_out   <= duty_to_pcm(17'(hi_sum), PWM_BITS);
                pcm_valid <= 1'b1;
                lock_cnt  <= lock_nxt;
                locked    <= (lock_nxt == LOCK_TGT);
            end else begin
                pos <= pos + POS_ONE;
                hi  <= hi_sum;
            end
        end
    end

endmodule

// File: tb/tb_mb_pwm_to_pcm.sv
// tb_mb_pwm_to_pcm: scoreboard bench driving constant, encoder-loopback, glitch and reset stimulus
module tb_mb_pwm_to_pcm;
    import mb_pwm_pkg::*;

    typedef struct {
        logic [15:0] pcm;
        logic        lk;
        int          per;
    } exp_t;

    logic pwm_clk = 1'b0;
    always #5 pwm_clk = ~pwm_clk;

    logic        rst_main = 1'b1;
    logic        rst_gen  = 1'b0;
    logic        rst;
    logic        rst4     = 1'b1;
    logic        pwm_in   = 1'b0;
    logic        pwm_in4  = 1'b0;
    logic [15:0] pcm_out, pcm_out4;
    logic        pcm_valid, pcm_valid4, locked, locked4;

    assign rst = rst_main | rst_gen;

    mb_pwm_to_pcm #(.PWM_BITS(8), .LOCK_FRAMES(4), .SYNC_STAGES(2)) dut (
        .pwm_clk  (pwm_clk),
        .rst      (rst),
        .pwm_in   (pwm_in),
        .pcm_out  (pcm_out),
        .pcm_valid(pcm_valid),
        .locked   (locked)
    );

    mb_pwm_to_pcm #(.PWM_BITS(4), .LOCK_FRAMES(4), .SYNC_STAGES(2)) dut4 (
        .pwm_clk  (pwm_clk),
        .rst      (rst4),
        .pwm_in   (pwm_in4),
        .pcm_out  (pcm_out4),
        .pcm_valid(pcm_valid4),
        .locked   (locked4)
    );

    int   nchk = 0, nfail = 0, cyc = 0;
    int   strobes = 0, strobes4 = 0, last_cyc = 0, last_cyc4 = 0;
    exp_t q[$];
    exp_t q4[$];
    int   mode = 0;
    int   duty_nxt = 128;
    logic c_lvl = 1'b0, track = 1'b0, track4 = 1'b0, run4 = 1'b0;
    logic glitch_arm = 1'b0, rst_arm = 1'b0, glitched = 1'b0, rst_hit = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected sample for a duty below full scale, derived from signed offset
    function automatic logic [15:0] exp_pcm(input int duty, input int bits);
        return 16'((duty - (1 << (bits - 1))) * (1 << (16 - bits)));
    endfunction

    initial forever begin
        @(posedge pwm_clk);
        cyc++;
    end

    // Stimulus generator: mode 0 constant, 1 encoder, 2 toggle
    initial begin
        int   cnt = 0;
        int   duty = 0;
        int   lk_cnt = 0;
        int   pend = 0;
        int   prev_mode = 0;
        logic gf = 1'b0;
        logic rf = 1'b0;
        forever begin
            @(posedge pwm_clk);
            #1;
            if (mode == 1 && prev_mode != 1) begin
                cnt = 0;
                lk_cnt = 0;
                pend = 0;
            end
            prev_mode = mode;
            if (mode == 2) pwm_in = ~pwm_in;
            else if (mode == 0) pwm_in = c_lvl;
            else begin
                if (cnt == 0) begin
                    duty = duty_nxt;
                    gf = glitch_arm && !glitched;
                    rf = rst_arm && !rst_hit;
                    if (gf || rf) begin
                        lk_cnt = 0;
                        pend = 512;
                    end else if (track) begin
                        lk_cnt = (lk_cnt < 4) ? lk_cnt + 1 : 4;
                        q.push_back('{exp_pcm(duty, 8), lk_cnt == 4, pend});
                        pend = 256;
                    end
                end
                pwm_in = (cnt < duty);
                if (gf && cnt == 100) begin
                    pwm_in = 1'b1;
                    glitched = 1'b1;
                end
                rst_gen = rf && cnt == 200;
                if (rf && cnt == 200) rst_hit = 1'b1;
                cnt = (cnt + 1) % 256;
            end
        end
    end

    initial begin
        int c = 0;
        int lk = 0;
        int pend = 0;
        forever begin
            @(posedge pwm_clk);
            #1;
            if (!run4) begin
                c = 0;
                lk = 0;
                pend = 0;
                pwm_in4 = 1'b0;
            end else begin
                if (c == 0 && track4) begin
                    lk = (lk < 4) ? lk + 1 : 4;
                    q4.push_back('{exp_pcm(15, 4), lk == 4, pend});
                    pend = 16;
                end
                pwm_in4 = (c < 15);
                c = (c + 1) % 16;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge pwm_clk);
            if (pcm_valid) begin
                strobes++;
                check("strobe_expected", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("pcm_out", 32'(pcm_out), 32'(e.pcm));
                    check("locked_at_strobe", 32'(locked), 32'(e.lk));
                    if (e.per != 0) check("strobe_period", cyc - last_cyc, e.per);
                end
                last_cyc = cyc;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge pwm_clk);
            if (pcm_valid4) begin
                strobes4++;
                check("strobe4_expected", int'(q4.size() > 0), 1);
                if (q4.size() > 0) begin
                    e = q4.pop_front();
                    check("pcm_out4", 32'(pcm_out4), 32'(e.pcm));
                    check("locked4_at_strobe", 32'(locked4), 32'(e.lk));
                    if (e.per != 0) check("strobe4_period", cyc - last_cyc4, e.per);
                end
                last_cyc4 = cyc;
            end
        end
    end

    task automatic wait_strobes(input int n, input int budget);
        int target;
        int k;
        target = strobes + n;
        k = 0;
        while (strobes < target && k < budget) begin
            @(negedge pwm_clk);
            k++;
        end
        check("strobe_wait", int'(strobes >= target), 1);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (q.size() != 0 && k < budget) begin
            @(negedge pwm_clk);
            k++;
        end
        check("drain", q.size(), 0);
    endtask

    initial begin
        int c_rel;
        int k;
        mode = 2;
        repeat (3) begin
            @(negedge pwm_clk);
            check("rst_pcm_valid", 32'(pcm_valid), 0);
            check("rst_pcm_out", 32'(pcm_out), 32'h0000);
            check("rst_locked", 32'(locked), 0);
        end
        mode = 0;
        c_lvl = 1'b0;
        repeat (2) @(negedge pwm_clk);
        rst_main = 1'b0;
        c_rel = cyc;
        repeat (10) @(negedge pwm_clk);
        check("post_rst_locked", 32'(locked), 0);
        check("post_rst_pcm_out", 32'(pcm_out), 32'h0000);
        q.push_back('{16'h8000, 1'b0, 0});
        q.push_back('{16'h8000, 1'b0, 256});
        q.push_back('{16'h8000, 1'b0, 256});
        q.push_back('{16'h8000, 1'b1, 256});
        q.push_back('{16'h8000, 1'b1, 256});
        wait_strobes(1, 700);
        check("first_strobe_window", int'(last_cyc - c_rel >= 511 && last_cyc - c_rel <= 515), 1);
        drain(1200);

        c_lvl = 1'b1;
        q.push_back('{16'h7FFF, 1'b0, 0});
        q.push_back('{16'h7FFF, 1'b0, 256});
        q.push_back('{16'h7FFF, 1'b0, 256});
        q.push_back('{16'h7FFF, 1'b1, 256});
        drain(1300);

        c_lvl = 1'b0;
        rst_main = 1'b1;
        repeat (3) @(negedge pwm_clk);
        rst_main = 1'b0;
        repeat (2) @(negedge pwm_clk);
        duty_nxt = 128;
        track = 1'b1;
        mode = 1;
        wait_strobes(6, 2000);
        duty_nxt = 0;
        wait_strobes(2, 800);
        duty_nxt = 255;
        wait_strobes(3, 1000);
        duty_nxt = 64;
        wait_strobes(5, 1600);
        check("locked_before_glitch", 32'(locked), 1);

        glitch_arm = 1'b1;
        k = 0;
        while (!glitched && k < 1000) begin
            @(negedge pwm_clk);
            k++;
        end
        check("glitch_injected", 32'(glitched), 1);
        repeat (6) @(negedge pwm_clk);
        check("locked_drops_after_glitch", 32'(locked), 0);
        wait_strobes(5, 2000);

        rst_arm = 1'b1;
        k = 0;
        while (!rst_gen && k < 1000) begin
            @(negedge pwm_clk);
            k++;
        end
        check("mid_reset_applied", 32'(rst_gen), 1);
        @(negedge pwm_clk);
        check("mid_reset_state", 32'(dut.state), 32'(SEEK));
        check("mid_reset_locked", 32'(locked), 0);
        check("mid_reset_valid", 32'(pcm_valid), 0);
        wait_strobes(5, 2000);
        track = 1'b0;
        drain(800);

        rst_main = 1'b1;
        repeat (2) @(negedge pwm_clk);
        rst4 = 1'b0;
        repeat (2) @(negedge pwm_clk);
        track4 = 1'b1;
        run4 = 1'b1;
        k = 0;
        while (strobes4 < 6 && k < 300) begin
            @(negedge pwm_clk);
            k++;
        end
        check("strobe4_wait", int'(strobes4 >= 6), 1);
        track4 = 1'b0;
        k = 0;
        while (q4.size() != 0 && k < 100) begin
            @(negedge pwm_clk);
            k++;
        end
        check("drain4", q4.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycles=%0d limit=100000", cyc);
        $fatal(1, "watchdog");
    end

endmodule
